// File: rtl/layer_compositor_pkg.sv
// -----------------------------------------------------------------------------
// layer_compositor_pkg
//   Shared definitions for the layer compositor: channel count of a packed
//   {R,G,B} word and the index-width helper used to size the layer select.
// -----------------------------------------------------------------------------
package layer_compositor_pkg;

   // Channels in a packed colour word, ordered {R,G,B} from MSB down.
   localparam int RGB_CH = 3;

   // Number of bits needed to hold the value n itself, not ceil(log2(n)).
   // Sizing the layer select this way leaves room for indices >= n.
   // That lets an out-of-range layer reach the compositor and be rejected
   // there, instead of silently aliasing onto a real layer.
   function automatic int clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) <= n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/layer_compositor_rect_hit.sv
// -----------------------------------------------------------------------------
// layer_compositor_rect_hit
//   Combinational point-in-rectangle test for one compositor layer.
//   Ports:
//     x, y           current pixel coordinate
//     rect_x, rect_y top-left corner of the layer
//     rect_w, rect_h layer size in pixels; a zero size never hits
//     en             layer enable
//     vis            layer currently visible (blink phase already folded in)
//     hit            pixel lies inside an enabled, visible layer
// -----------------------------------------------------------------------------
module layer_compositor_rect_hit #(
   parameter int COORD_W = 11
) (
   input  logic [COORD_W-1:0] x,
   input  logic [COORD_W-1:0] y,
   input  logic [COORD_W-1:0] rect_x,
   input  logic [COORD_W-1:0] rect_y,
   input  logic [COORD_W-1:0] rect_w,
   input  logic [COORD_W-1:0] rect_h,
   input  logic               en,
   input  logic               vis,
   output logic               hit
);

   // One extra bit on the far edges, so a layer that runs past the largest
   // coordinate is clipped rather than wrapping back to the origin.
   logic [COORD_W:0] x_end;
   logic [COORD_W:0] y_end;
   logic             in_x;
   logic             in_y;

   assign x_end = {1'b0, rect_x} + {1'b0, rect_w};
   assign y_end = {1'b0, rect_y} + {1'b0, rect_h};

   assign in_x = (x >= rect_x) && ({1'b0, x} < x_end);
   assign in_y = (y >= rect_y) && ({1'b0, y} < y_end);

   assign hit = en && vis && in_x && in_y;

endmodule

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
//   Per-pixel colour source placed between the VGA timing core and the DACs.
//   N_LAYERS rectangles are composited over a background colour. Layer 0 has
//   the highest priority. Host configuration is written to pending registers.
//   Those are copied to the active set only on entry to vertical blank, so a
//   visible frame never mixes old and new geometry.
//   Ports:
//     CLOCK_50            pixel clock
//     reset               asynchronous active-low reset
//     x_coord, y_coord    current pixel from the timing core
//     cfg_we              one-cycle write strobe for one layer
//     cfg_layer           target layer; values >= N_LAYERS are dropped
//     cfg_x/y/w/h         layer geometry
//     cfg_rgb             layer colour {R,G,B}
//     cfg_en, cfg_blink   layer enable, blink participation
//     frame_start         one-cycle pulse after entry to vertical blank
//     top_R/G/B           composited colour, 2 clocks after x/y
//     pix_x, pix_y        coordinates aligned with top_R/G/B
// -----------------------------------------------------------------------------
module layer_compositor
   import layer_compositor_pkg::*;
#(
   parameter int                          N_LAYERS     = 4,
   parameter int                          COORD_W      = 11,
   parameter int                          COLOR_W      = 8,
   parameter int                          H_ACTIVE     = 640,
   parameter int                          V_ACTIVE     = 480,
   parameter int                          BLINK_FRAMES = 30,
   parameter logic [RGB_CH*COLOR_W-1:0]   BG_RGB       = 24'hFFFFFF
) (
   input  logic                           CLOCK_50,
   input  logic                           reset,
   input  logic [COORD_W-1:0]             x_coord,
   input  logic [COORD_W-1:0]             y_coord,
   input  logic                           cfg_we,
   input  logic [clog2(N_LAYERS)-1:0]     cfg_layer,
   input  logic [COORD_W-1:0]             cfg_x,
   input  logic [COORD_W-1:0]             cfg_y,
   input  logic [COORD_W-1:0]             cfg_w,
   input  logic [COORD_W-1:0]             cfg_h,
   input  logic [RGB_CH*COLOR_W-1:0]      cfg_rgb,
   input  logic                           cfg_en,
   input  logic                           cfg_blink,
   output logic                           frame_start,
   output logic [COLOR_W-1:0]             top_R,
   output logic [COLOR_W-1:0]             top_G,
   output logic [COLOR_W-1:0]             top_B,
   output logic [COORD_W-1:0]             pix_x,
   output logic [COORD_W-1:0]             pix_y
);

   localparam int LAYER_W = clog2(N_LAYERS);
   localparam int RGB_W   = RGB_CH * COLOR_W;
   localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   localparam logic [COORD_W-1:0] H_LIM      = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_LIM      = COORD_W'(V_ACTIVE);
   localparam logic [LAYER_W-1:0] LAYER_LIM  = LAYER_W'(N_LAYERS);
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

   // Reset: asserts asynchronously and releases synchronously.
   logic [1:0] rst_pipe;
   logic       rst_n;

   always_ff @(posedge CLOCK_50 or negedge reset) begin
      if (!reset) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end

   assign rst_n = rst_pipe[1];

   // Frame boundary detection.
   logic [COORD_W-1:0] y_prev;
   logic               fs_det;
   logic               cfg_wr;

   assign fs_det = (y_coord == V_LIM) && (y_prev != V_LIM);
   assign cfg_wr = cfg_we && (cfg_layer < LAYER_LIM);

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         y_prev      <= '0;
         frame_start <= 1'b0;
      end else begin
         y_prev      <= y_coord;
         frame_start <= fs_det;
      end
   end

   // Pending (host-written) and active (display) layer registers.
   logic [COORD_W-1:0] pend_x     [N_LAYERS];
   logic [COORD_W-1:0] pend_y     [N_LAYERS];
   logic [COORD_W-1:0] pend_w     [N_LAYERS];
   logic [COORD_W-1:0] pend_h     [N_LAYERS];
   logic [RGB_W-1:0]   pend_rgb   [N_LAYERS];
   logic               pend_en    [N_LAYERS];
   logic               pend_blink [N_LAYERS];

   logic [COORD_W-1:0] act_x      [N_LAYERS];
   logic [COORD_W-1:0] act_y      [N_LAYERS];
   logic [COORD_W-1:0] act_w      [N_LAYERS];
   logic [COORD_W-1:0] act_h      [N_LAYERS];
   logic [RGB_W-1:0]   act_rgb    [N_LAYERS];
   logic               act_en     [N_LAYERS];
   logic               act_blink  [N_LAYERS];

   // Both updates are non-blocking in one block. On a frame edge that also
   // carries a write, active receives the pending value from before that write.
   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LAYERS; i++) begin
            pend_x[i]     <= '0;
            pend_y[i]     <= '0;
            pend_w[i]     <= '0;
            pend_h[i]     <= '0;
            pend_rgb[i]   <= '0;
            pend_en[i]    <= 1'b0;
            pend_blink[i] <= 1'b0;
            act_x[i]      <= '0;
            act_y[i]      <= '0;
            act_w[i]      <= '0;
            act_h[i]      <= '0;
            act_rgb[i]    <= '0;
            act_en[i]     <= 1'b0;
            act_blink[i]  <= 1'b0;
         end
      end else begin
         for (int i = 0; i < N_LAYERS; i++) begin
            if (cfg_wr && (cfg_layer == LAYER_W'(i))) begin
               pend_x[i]     <= cfg_x;
               pend_y[i]     <= cfg_y;
               pend_w[i]     <= cfg_w;
               pend_h[i]     <= cfg_h;
               pend_rgb[i]   <= cfg_rgb;
               pend_en[i]    <= cfg_en;
               pend_blink[i] <= cfg_blink;
            end
            if (fs_det) begin
               act_x[i]      <= pend_x[i];
               act_y[i]      <= pend_y[i];
               act_w[i]      <= pend_w[i];
               act_h[i]      <= pend_h[i];
               act_rgb[i]    <= pend_rgb[i];
               act_en[i]     <= pend_en[i];
               act_blink[i]  <= pend_blink[i];
            end
         end
      end
   end

   // Blink phase: toggles every BLINK_FRAMES frame boundaries.
   logic [BLINK_W-1:0] blink_cnt;
   logic               blink_on;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt <= '0;
         blink_on  <= 1'b1;
      end else if (fs_det) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= ~blink_on;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // Stage 1: per-layer hit test.
   logic [N_LAYERS-1:0] hit_c;

   for (genvar g = 0; g < N_LAYERS; g++) begin : g_layer
      layer_compositor_rect_hit #(
         .COORD_W (COORD_W)
      ) u_hit (
         .x      (x_coord),
         .y      (y_coord),
         .rect_x (act_x[g]),
         .rect_y (act_y[g]),
         .rect_w (act_w[g]),
         .rect_h (act_h[g]),
         .en     (act_en[g]),
         .vis    (!act_blink[g] || blink_on),
         .hit    (hit_c[g])
      );
   end

   logic [N_LAYERS-1:0] hit_q;
   logic                blank_q;
   logic [COORD_W-1:0]  x_q;
   logic [COORD_W-1:0]  y_q;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         hit_q   <= '0;
         blank_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         hit_q   <= hit_c;
         blank_q <= (x_coord >= H_LIM) || (y_coord >= V_LIM);
         x_q     <= x_coord;
         y_q     <= y_coord;
      end
   end

   // Stage 2: priority select. The loop walks from the lowest priority layer
   // up, so the lowest-index hit is the last one to assign.
   logic [RGB_W-1:0] sel_rgb;

   always_comb begin
      sel_rgb = BG_RGB;
      for (int i = N_LAYERS - 1; i >= 0; i--) begin
         if (hit_q[i]) sel_rgb = act_rgb[i];
      end
      if (blank_q) sel_rgb = '0;
   end

   logic [RGB_W-1:0] rgb_q;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         rgb_q <= '0;
         pix_x <= '0;
         pix_y <= '0;
      end else begin
         rgb_q <= sel_rgb;
         pix_x <= x_q;
         pix_y <= y_q;
      end
   end

   assign top_R = rgb_q[3*COLOR_W-1:2*COLOR_W];
   assign top_G = rgb_q[2*COLOR_W-1:COLOR_W];
   assign top_B = rgb_q[COLOR_W-1:0];

endmodule
